// File: rtl/soc_pkg.sv
// Shared definitions for the spike-detection SoC: sizes, reset values,
// host address map, CTRL bit positions and the sample magnitude helper.
// Optional feature macro: SOC_REFRACTORY_EN (per-channel refractory blanking).
package soc_pkg;

    localparam int NUM_CH   = 16;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 10;
    localparam int CH_IDX_W = 4;

    localparam logic [DATA_W-1:0] THRESH_DEFAULT  = 16'h0400;
    localparam logic [DATA_W-1:0] REFRACT_DEFAULT = 16'd4;

    // Word addresses seen by the host. Channel banks are 16 words long and
    // aligned, so the bank is addr[9:4] and the channel is addr[3:0].
    localparam logic [ADDR_W-1:0] SAMPLE_BASE  = 10'h000;
    localparam logic [ADDR_W-1:0] THRESH_BASE  = 10'h010;
    localparam logic [ADDR_W-1:0] CTRL_ADDR    = 10'h020;
    localparam logic [ADDR_W-1:0] FLAGS_ADDR   = 10'h021;
    localparam logic [ADDR_W-1:0] REFRACT_ADDR = 10'h022;
    localparam logic [ADDR_W-1:0] COUNT_BASE   = 10'h030;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLR_BIT    = 1;

    // Magnitude of a signed sample. The most negative value has no positive
    // counterpart, so it is clamped to the largest positive value.
    function automatic logic [DATA_W-1:0] sample_mag(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] m;
        m = s;
        if (s[DATA_W-1]) begin
            if (s == {1'b1, {(DATA_W-1){1'b0}}}) begin
                m = {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                m = ~s + {{(DATA_W-1){1'b0}}, 1'b1};
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/soc_top_spike_channel.sv
// One detection channel: holds the last sample, its threshold, the sticky
// hit flag, a saturating hit counter and the registered spike output.
// With SOC_REFRACTORY_EN defined, a refractory down-counter blanks the
// samples that follow a hit.
module spike_channel
    import soc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_sample_we,
    input  logic              i_thresh_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_enable,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_refract,
    output logic [DATA_W-1:0] o_sample,
    output logic [DATA_W-1:0] o_thresh,
    output logic [DATA_W-1:0] o_count,
    output logic              o_flag,
    output logic              o_spike
);

    logic [DATA_W-1:0] r_sample;
    logic [DATA_W-1:0] r_thresh;
    logic [DATA_W-1:0] r_count;
    logic              r_flag;
    logic              r_spike;
    logic              w_blank;
    logic              w_hit;
    logic [DATA_W-1:0] w_mag;

    // The incoming sample is compared directly so the result lands on the
    // same edge that stores the sample.
    assign w_mag = sample_mag(i_wdata);

`ifdef SOC_REFRACTORY_EN
    logic [DATA_W-1:0] r_refr;

    assign w_blank = (r_refr != '0);

    // Refractory counter: loaded on a hit, stepped down by each blanked sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refr <= '0;
        end else if (i_sample_we) begin
            if (w_blank) begin
                r_refr <= r_refr - {{(DATA_W-1){1'b0}}, 1'b1};
            end else if (w_hit) begin
                r_refr <= i_refract;
            end
        end
    end
`else
    logic w_unused_refract;

    assign w_blank          = 1'b0;
    assign w_unused_refract = ^i_refract;
`endif

    assign w_hit = i_sample_we && i_enable && !w_blank && (w_mag > r_thresh);

    // Sample and threshold storage written by the host.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample <= '0;
            r_thresh <= THRESH_DEFAULT;
        end else begin
            if (i_sample_we) begin
                r_sample <= i_wdata;
            end
            if (i_thresh_we) begin
                r_thresh <= i_wdata;
            end
        end
    end

    // Spike output follows each sample write and holds until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_spike <= 1'b0;
        end else if (i_sample_we) begin
            r_spike <= w_hit;
        end
    end

    // Sticky flag and saturating counter; clear has priority over a hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flag  <= 1'b0;
            r_count <= '0;
        end else if (i_clr) begin
            r_flag  <= 1'b0;
            r_count <= '0;
        end else if (w_hit) begin
            r_flag <= 1'b1;
            if (r_count != {DATA_W{1'b1}}) begin
                r_count <= r_count + {{(DATA_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_sample = r_sample;
    assign o_thresh = r_thresh;
    assign o_count  = r_count;
    assign o_flag   = r_flag;
    assign o_spike  = r_spike;

endmodule

// File: rtl/soc_top.sv
// Spike-detection SoC top: host register port decode, CTRL register,
// registered read mux, and NUM_CH spike_channel instances.
// Optional feature macro: SOC_REFRACTORY_EN adds the REFRACT register.
module soc_top
    import soc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              risc_v_read,
    input  logic              risc_v_write,
    input  logic [ADDR_W-1:0] risc_v_addr,
    input  logic [31:0]       risc_v_data_in,
    output logic [DATA_W-1:0] risc_v_data_out,
    output logic [NUM_CH-1:0] spike_detected
);

    logic [DATA_W-1:0]   w_wdata;
    logic [CH_IDX_W-1:0] w_ch;
    logic [5:0]          w_bank;
    logic                w_is_sample;
    logic                w_is_thresh;
    logic                w_is_count;
    logic                w_ctrl_we;
    logic                w_clr;
    logic                w_unused_data;
    logic [DATA_W-1:0]   w_refract;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   w_ctrl_rd;

    logic [NUM_CH-1:0]   w_sample_we;
    logic [NUM_CH-1:0]   w_thresh_we;
    logic [NUM_CH-1:0]   w_flags;
    logic [NUM_CH-1:0]   w_spike;
    logic [DATA_W-1:0]   w_sample [NUM_CH];
    logic [DATA_W-1:0]   w_thresh [NUM_CH];
    logic [DATA_W-1:0]   w_count  [NUM_CH];

    logic                r_enable;
    logic [DATA_W-1:0]   r_rdata;

    assign w_wdata       = risc_v_data_in[DATA_W-1:0];
    assign w_unused_data = ^risc_v_data_in[31:DATA_W];
    assign w_ch          = risc_v_addr[CH_IDX_W-1:0];
    assign w_bank        = risc_v_addr[ADDR_W-1:CH_IDX_W];
    assign w_is_sample   = (w_bank == SAMPLE_BASE[ADDR_W-1:CH_IDX_W]);
    assign w_is_thresh   = (w_bank == THRESH_BASE[ADDR_W-1:CH_IDX_W]);
    assign w_is_count    = (w_bank == COUNT_BASE[ADDR_W-1:CH_IDX_W]);
    assign w_ctrl_we     = risc_v_write && (risc_v_addr == CTRL_ADDR);
    // CLR is never stored: it acts only on the edge of the CTRL write.
    assign w_clr         = w_ctrl_we && w_wdata[CTRL_CLR_BIT];

    // ENABLE bit of CTRL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable <= 1'b1;
        end else if (w_ctrl_we) begin
            r_enable <= w_wdata[CTRL_ENABLE_BIT];
        end
    end

`ifdef SOC_REFRACTORY_EN
    logic [DATA_W-1:0] r_refract;

    // Refractory length shared by all channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refract <= REFRACT_DEFAULT;
        end else if (risc_v_write && (risc_v_addr == REFRACT_ADDR)) begin
            r_refract <= w_wdata;
        end
    end

    assign w_refract = r_refract;
`else
    assign w_refract = '0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_sample_we[g] = risc_v_write && w_is_sample && (w_ch == CH_IDX_W'(g));
        assign w_thresh_we[g] = risc_v_write && w_is_thresh && (w_ch == CH_IDX_W'(g));

        spike_channel u_ch (
            .clk         (clk),
            .reset       (reset),
            .i_sample_we (w_sample_we[g]),
            .i_thresh_we (w_thresh_we[g]),
            .i_wdata     (w_wdata),
            .i_enable    (r_enable),
            .i_clr       (w_clr),
            .i_refract   (w_refract),
            .o_sample    (w_sample[g]),
            .o_thresh    (w_thresh[g]),
            .o_count     (w_count[g]),
            .o_flag      (w_flags[g]),
            .o_spike     (w_spike[g])
        );
    end

    // Read mux over current register contents, so a same-cycle write is
    // not yet visible to the read.
    always_comb begin
        w_ctrl_rd                  = '0;
        w_ctrl_rd[CTRL_ENABLE_BIT] = r_enable;
        w_rdata                    = '0;
        if (w_is_sample) begin
            w_rdata = w_sample[w_ch];
        end else if (w_is_thresh) begin
            w_rdata = w_thresh[w_ch];
        end else if (w_is_count) begin
            w_rdata = w_count[w_ch];
        end else if (risc_v_addr == CTRL_ADDR) begin
            w_rdata = w_ctrl_rd;
        end else if (risc_v_addr == FLAGS_ADDR) begin
            w_rdata = w_flags;
`ifdef SOC_REFRACTORY_EN
        end else if (risc_v_addr == REFRACT_ADDR) begin
            w_rdata = r_refract;
`endif
        end
    end

    // Read data register: loads only on a read strobe, otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (risc_v_read) begin
            r_rdata <= w_rdata;
        end
    end

    assign risc_v_data_out = r_rdata;
    assign spike_detected  = w_spike;

endmodule

// File: tb/tb_soc_top.sv
// Directed self-checking bench for soc_top. Inputs change on the falling
// edge; outputs are observed on the falling edge after the active edge.
module tb_soc_top;

    logic        clk;
    logic        reset;
    logic        risc_v_read;
    logic        risc_v_write;
    logic [9:0]  risc_v_addr;
    logic [31:0] risc_v_data_in;
    logic [15:0] risc_v_data_out;
    logic [15:0] spike_detected;

    int n_checks;
    int n_fail;

    soc_top dut (
        .clk             (clk),
        .reset           (reset),
        .risc_v_read     (risc_v_read),
        .risc_v_write    (risc_v_write),
        .risc_v_addr     (risc_v_addr),
        .risc_v_data_in  (risc_v_data_in),
        .risc_v_data_out (risc_v_data_out),
        .spike_detected  (spike_detected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [9:0] addr, input logic [31:0] data);
        @(negedge clk);
        risc_v_write   = 1'b1;
        risc_v_addr    = addr;
        risc_v_data_in = data;
        @(negedge clk);
        risc_v_write   = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] addr, output logic [15:0] data);
        @(negedge clk);
        risc_v_read = 1'b1;
        risc_v_addr = addr;
        @(negedge clk);
        risc_v_read = 1'b0;
        data        = risc_v_data_out;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        reset          = 1'b1;
        risc_v_read    = 1'b0;
        risc_v_write   = 1'b0;
        risc_v_addr    = '0;
        risc_v_data_in = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (spike_detected !== 16'h0000) begin
            $display("FAIL reset_spike: got %h expected %h", spike_detected, 16'h0000);
            n_fail++;
        end
        n_checks++;
        if (risc_v_data_out !== 16'h0000) begin
            $display("FAIL reset_rdata: got %h expected %h", risc_v_data_out, 16'h0000);
            n_fail++;
        end
        reset = 1'b0;
        do_read(10'h010, rd);
        n_checks++;
        if (rd !== 16'h0400) begin
            $display("FAIL reset_thresh0: got %h expected %h", rd, 16'h0400);
            n_fail++;
        end
        do_read(10'h020, rd);
        n_checks++;
        if (rd !== 16'h0001) begin
            $display("FAIL reset_ctrl: got %h expected %h", rd, 16'h0001);
            n_fail++;
        end
        // Reset arriving while a read is in flight must leave data_out at 0.
        @(negedge clk);
        risc_v_read = 1'b1;
        risc_v_addr = 10'h01F;
        #2 reset = 1'b1;
        @(negedge clk);
        risc_v_read = 1'b0;
        n_checks++;
        if (risc_v_data_out !== 16'h0000) begin
            $display("FAIL reset_abort_read: got %h expected %h", risc_v_data_out, 16'h0000);
            n_fail++;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_hit();
        logic [15:0] rd;
        do_write(10'h000, 32'h12345678);
        n_checks++;
        if (spike_detected !== 16'h0001) begin
            $display("FAIL basic_spike: got %h expected %h", spike_detected, 16'h0001);
            n_fail++;
        end
        do_read(10'h030, rd);
        n_checks++;
        if (rd !== 16'h0001) begin
            $display("FAIL basic_count0: got %h expected %h", rd, 16'h0001);
            n_fail++;
        end
        do_read(10'h021, rd);
        n_checks++;
        if (rd !== 16'h0001) begin
            $display("FAIL basic_flags: got %h expected %h", rd, 16'h0001);
            n_fail++;
        end
        do_read(10'h000, rd);
        n_checks++;
        if (rd !== 16'h5678) begin
            $display("FAIL basic_sample_rb: got %h expected %h", rd, 16'h5678);
            n_fail++;
        end
    endtask

    task automatic test_threshold();
        logic [15:0] rd;
        do_write(10'h013, 32'h0000_1000);
        do_read(10'h013, rd);
        n_checks++;
        if (rd !== 16'h1000) begin
            $display("FAIL thresh3_rb: got %h expected %h", rd, 16'h1000);
            n_fail++;
        end
        do_write(10'h003, 32'h0000_1000);
        n_checks++;
        if (spike_detected[3] !== 1'b0) begin
            $display("FAIL thresh_equal_nohit: got %b expected %b", spike_detected[3], 1'b0);
            n_fail++;
        end
        do_write(10'h003, 32'h0000_EFFF);
        n_checks++;
        if (spike_detected !== 16'h0009) begin
            $display("FAIL thresh_neg_hit: got %h expected %h", spike_detected, 16'h0009);
            n_fail++;
        end
    endtask

    task automatic test_min_negative();
        logic [15:0] rd;
        do_write(10'h015, 32'h0000_7FFE);
        do_write(10'h005, 32'h0000_8000);
        n_checks++;
        if (spike_detected[5] !== 1'b1) begin
            $display("FAIL minneg_hit: got %b expected %b", spike_detected[5], 1'b1);
            n_fail++;
        end
        do_write(10'h015, 32'h0000_7FFF);
        do_write(10'h005, 32'h0000_8000);
        n_checks++;
        if (spike_detected[5] !== 1'b0) begin
            $display("FAIL minneg_nohit: got %b expected %b", spike_detected[5], 1'b0);
            n_fail++;
        end
        do_read(10'h035, rd);
        n_checks++;
        if (rd !== 16'h0001) begin
            $display("FAIL minneg_count5: got %h expected %h", rd, 16'h0001);
            n_fail++;
        end
    endtask

    task automatic test_enable_clr();
        logic [15:0] rd;
        do_write(10'h020, 32'h0000_0000);
        do_read(10'h020, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            $display("FAIL ctrl_disabled_rb: got %h expected %h", rd, 16'h0000);
            n_fail++;
        end
        do_write(10'h000, 32'h0000_7FFF);
        n_checks++;
        if (spike_detected[0] !== 1'b0) begin
            $display("FAIL disabled_spike0: got %b expected %b", spike_detected[0], 1'b0);
            n_fail++;
        end
        do_read(10'h030, rd);
        n_checks++;
        if (rd !== 16'h0001) begin
            $display("FAIL disabled_count0: got %h expected %h", rd, 16'h0001);
            n_fail++;
        end
        do_read(10'h021, rd);
        n_checks++;
        if (rd !== 16'h0029) begin
            $display("FAIL flags_before_clr: got %h expected %h", rd, 16'h0029);
            n_fail++;
        end
        do_write(10'h020, 32'h0000_0003);
        do_read(10'h021, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            $display("FAIL clr_flags: got %h expected %h", rd, 16'h0000);
            n_fail++;
        end
        do_read(10'h033, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            $display("FAIL clr_count3: got %h expected %h", rd, 16'h0000);
            n_fail++;
        end
        do_read(10'h020, rd);
        n_checks++;
        if (rd !== 16'h0001) begin
            $display("FAIL clr_ctrl_rb: got %h expected %h", rd, 16'h0001);
            n_fail++;
        end
        n_checks++;
        if (spike_detected !== 16'h0008) begin
            $display("FAIL clr_keeps_spike: got %h expected %h", spike_detected, 16'h0008);
            n_fail++;
        end
    endtask

    task automatic test_read_write_same();
        logic [15:0] rd;
        @(negedge clk);
        risc_v_read    = 1'b1;
        risc_v_write   = 1'b1;
        risc_v_addr    = 10'h010;
        risc_v_data_in = 32'h0000_ABCD;
        @(negedge clk);
        risc_v_read    = 1'b0;
        risc_v_write   = 1'b0;
        n_checks++;
        if (risc_v_data_out !== 16'h0400) begin
            $display("FAIL rw_same_old: got %h expected %h", risc_v_data_out, 16'h0400);
            n_fail++;
        end
        do_read(10'h010, rd);
        n_checks++;
        if (rd !== 16'hABCD) begin
            $display("FAIL rw_same_new: got %h expected %h", rd, 16'hABCD);
            n_fail++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (risc_v_data_out !== 16'hABCD) begin
            $display("FAIL rdata_hold: got %h expected %h", risc_v_data_out, 16'hABCD);
            n_fail++;
        end
        do_write(10'h3FF, 32'h0000_5555);
        do_read(10'h3FF, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            $display("FAIL unmapped_read: got %h expected %h", rd, 16'h0000);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd;
        @(negedge clk);
        risc_v_write   = 1'b1;
        risc_v_addr    = 10'h007;
        risc_v_data_in = 32'h0000_2000;
        @(negedge clk);
        n_checks++;
        if (spike_detected[7] !== 1'b1) begin
            $display("FAIL b2b_spike7_hit: got %b expected %b", spike_detected[7], 1'b1);
            n_fail++;
        end
        risc_v_addr    = 10'h008;
        risc_v_data_in = 32'h0000_F000;
        @(negedge clk);
        risc_v_addr    = 10'h007;
        risc_v_data_in = 32'h0000_0001;
        @(negedge clk);
        risc_v_write   = 1'b0;
        n_checks++;
        if (spike_detected[8:7] !== 2'b10) begin
            $display("FAIL b2b_spike87: got %b expected %b", spike_detected[8:7], 2'b10);
            n_fail++;
        end
        do_read(10'h037, rd);
        n_checks++;
        if (rd !== 16'h0001) begin
            $display("FAIL b2b_count7: got %h expected %h", rd, 16'h0001);
            n_fail++;
        end
        do_read(10'h038, rd);
        n_checks++;
        if (rd !== 16'h0001) begin
            $display("FAIL b2b_count8: got %h expected %h", rd, 16'h0001);
            n_fail++;
        end
    endtask

`ifdef SOC_REFRACTORY_EN
    task automatic test_refractory();
        logic [15:0] rd;
        logic [3:0]  exp_seq;
        exp_seq = 4'b1001;
        do_read(10'h022, rd);
        n_checks++;
        if (rd !== 16'h0004) begin
            $display("FAIL refract_default: got %h expected %h", rd, 16'h0004);
            n_fail++;
        end
        do_write(10'h022, 32'h0000_0002);
        for (int i = 0; i < 4; i++) begin
            do_write(10'h001, 32'h0000_2000);
            n_checks++;
            if (spike_detected[1] !== exp_seq[3-i]) begin
                $display("FAIL refract_seq%0d: got %b expected %b", i, spike_detected[1], exp_seq[3-i]);
                n_fail++;
            end
        end
        do_read(10'h031, rd);
        n_checks++;
        if (rd !== 16'h0002) begin
            $display("FAIL refract_count1: got %h expected %h", rd, 16'h0002);
            n_fail++;
        end
    endtask
`else
    task automatic test_refractory();
        logic [15:0] rd;
        do_write(10'h022, 32'h0000_0005);
        do_read(10'h022, rd);
        n_checks++;
        if (rd !== 16'h0000) begin
            $display("FAIL refract_absent: got %h expected %h", rd, 16'h0000);
            n_fail++;
        end
        do_write(10'h001, 32'h0000_2000);
        do_write(10'h001, 32'h0000_2000);
        n_checks++;
        if (spike_detected[1] !== 1'b1) begin
            $display("FAIL no_blanking: got %b expected %b", spike_detected[1], 1'b1);
            n_fail++;
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_hit();
        test_threshold();
        test_min_negative();
        test_enable_clr();
        test_read_write_same();
        test_back_to_back();
        test_refractory();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
